ber_meter: RTL

//  Receive-side bit-error-rate meter fed by the rx slicer output (dx) and the local PRBS reference bit (sx).

---
 rtl/ber_meter_pkg.sv | 35 +++
 rtl/ber_meter_bit_delay_line.sv | 46 ++++
 rtl/ber_meter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ber_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ber_meter_pkg
// Description : Shared types and constants for the BER meter. Provides the
//               lock-state enum, default parameter values and a constant
//               ceil(log2()) helper used to size window counters.
// Revision    : 1.0 - initial release
// ============================================================================
package ber_meter_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_DELAY_W    = 10;
  localparam int DEF_SYNC_WIN   = 511;
  localparam int DEF_SEARCH_THR = 0;
  localparam int DEF_LOSS_THR   = 8;
  localparam int DEF_CNT_W      = 64;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ber_meter_bit_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : bit_delay_line
// Description : Enable-gated bit shift register with a run-time tap select.
//               dout is din delayed by `tap` enables; tap = 0 passes the
//               current din straight through.
// Ports       : clk    - clock
//               rst    - asynchronous active-low reset (clears history)
//               enable - shift strobe
//               din    - input bit
//               tap    - delay in enables, 0 .. 2**DEPTH_W-1
//               dout   - delayed bit
// Revision    : 1.0 - initial release
// ============================================================================
module bit_delay_line #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               din,
  input  logic [DEPTH_W-1:0] tap,
  output logic               dout
);

  localparam int c_DEPTH = 2 ** DEPTH_W;

  // r_sr[k] holds din from k+1 enables ago; the largest tap needs
  // c_DEPTH-1 bits of history.
  logic [c_DEPTH-2:0] r_sr;
  logic [c_DEPTH-1:0] w_taps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (enable) begin
      r_sr <= {r_sr[c_DEPTH-3:0], din};
    end
  end

  // Bit 0 is the live input so that tap = 0 means "no delay".
  assign w_taps = {r_sr, din};
  assign dout   = w_taps[tap];

endmodule
`default_nettype wire

// File: rtl/ber_meter.sv
`default_nettype none
// ============================================================================
// Module      : ber_meter
// Description : Receive-side bit-error-rate meter. Sweeps a reference delay
//               tap one window at a time until the received stream matches
//               the delayed reference, then locks and accumulates saturating
//               bit/error counters. Falls back to searching on loss of lock.
// Ports       : clk       - system clock
//               rst       - asynchronous active-low reset
//               enable    - one-clock bit strobe; gates all sampling
//               sx        - reference PRBS bit
//               dx        - received bit
//               clr       - synchronous counter clear (lock unaffected)
//               locked    - 1 while in LOCKED
//               delay     - current reference delay tap, in enables
//               bit_count - bits compared since lock/clr
//               err_count - mismatches since lock/clr
// Revision    : 1.0 - initial release
// ============================================================================
module ber_meter
  import ber_meter_pkg::*;
#(
  parameter int DELAY_W    = DEF_DELAY_W,
  parameter int SYNC_WIN   = DEF_SYNC_WIN,
  parameter int SEARCH_THR = DEF_SEARCH_THR,
  parameter int LOSS_THR   = DEF_LOSS_THR,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               sx,
  input  logic               dx,
  input  logic               clr,
  output logic               locked,
  output logic [DELAY_W-1:0] delay,
  output logic [CNT_W-1:0]   bit_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam int c_WCNT_W = (clog2(SYNC_WIN) < 1) ? 1 : clog2(SYNC_WIN);
  localparam int c_WERR_W = clog2(SYNC_WIN + 1);

  // Thresholds are clamped to the window length so they fit the error
  // counter; a window can never hold more than SYNC_WIN errors anyway.
  localparam int c_SEARCH_CLAMP = (SEARCH_THR > SYNC_WIN) ? SYNC_WIN : SEARCH_THR;
  localparam int c_LOSS_CLAMP   = (LOSS_THR > SYNC_WIN) ? SYNC_WIN : LOSS_THR;

  localparam logic [c_WCNT_W-1:0] c_WIN_LAST   = c_WCNT_W'(SYNC_WIN - 1);
  localparam logic [c_WCNT_W-1:0] c_WCNT_ONE   = c_WCNT_W'(1);
  localparam logic [c_WERR_W-1:0] c_SEARCH_THR = c_WERR_W'(c_SEARCH_CLAMP);
  localparam logic [c_WERR_W-1:0] c_LOSS_THR   = c_WERR_W'(c_LOSS_CLAMP);
  localparam logic [DELAY_W-1:0]  c_DELAY_ONE  = DELAY_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE    = CNT_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DELAY_W-1:0]    r_delay;
  logic [c_WCNT_W-1:0]   r_win_cnt;
  logic [c_WERR_W-1:0]   r_win_err;
  logic [c_WERR_W-1:0]   w_win_err_sum;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      r_err_cnt;
  logic                  w_ref;
  logic                  w_mismatch;
  logic                  w_win_end;
  logic                  w_enter_lock;
  logic                  w_step_delay;

  bit_delay_line #(
    .DEPTH_W (DELAY_W)
  ) u_delay_line (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .din    (sx),
    .tap    (r_delay),
    .dout   (w_ref)
  );

  assign w_mismatch = enable & (dx ^ w_ref);
  assign w_win_end  = enable & (r_win_cnt == c_WIN_LAST);

  // Error total including the current bit, so the window-closing enable
  // takes part in its own window's decision.
  assign w_win_err_sum = (&r_win_err) ? r_win_err
                                      : r_win_err + c_WERR_W'(w_mismatch);

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_lock = 1'b0;
    w_step_delay = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_win_end) begin
          if (w_win_err_sum <= c_SEARCH_THR) begin
            w_state_nxt  = LOCKED;
            w_enter_lock = 1'b1;
          end else begin
            w_step_delay = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (w_win_end && (w_win_err_sum > c_LOSS_THR)) begin
          w_state_nxt  = SEARCH;
          w_step_delay = 1'b1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (enable) begin
      if (w_win_end) begin
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + c_WCNT_ONE;
        r_win_err <= w_win_err_sum;
      end
    end
  end

  // Tap wraps naturally from all-ones back to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_delay <= '0;
    end else if (w_step_delay) begin
      r_delay <= r_delay + c_DELAY_ONE;
    end
  end

  // clr outranks a same-cycle enable; counters hold once lock is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (clr || w_enter_lock) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (enable && (r_state == LOCKED)) begin
      if (!(&r_bit_cnt)) begin
        r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
      end
      if (w_mismatch && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + c_CNT_ONE;
      end
    end
  end

  assign locked    = (r_state == LOCKED);
  assign delay     = r_delay;
  assign bit_count = r_bit_cnt;
  assign err_count = r_err_cnt;

endmodule
`default_nettype wire
